// File: rtl/mseq_pkg.sv
// Shared types and default widths for the micro sequencer.
// Optional looping is enabled by defining MSEQ_LOOP_EN.
package mseq_pkg;

  localparam int UADDR_W_DEF = 8;
  localparam int UWORD_W_DEF = 33;
  localparam int DADDR_W_DEF = 11;
  localparam int LOOP_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mseq_state_t;

  // Microword field layout, MSB first: ALU[32:29] SH[28:27] KMx[26] M[25:24]
  // B[23:18] C[17:12] T[11:5] A[4:0]
  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] sh;
    logic       kmx;
    logic [1:0] m;
    logic [5:0] b;
    logic [5:0] c;
    logic [6:0] t;
    logic [4:0] a;
  } uword_t;

endpackage

// File: rtl/mseq_fifo2.sv
// Two-entry fall-through buffer with flush; when empty the incoming word is
// presented directly so a returning ROM word can be consumed in the same cycle.
module mseq_fifo2 #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  input  logic         head_ready,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         empty;
  logic         store;
  logic         drop_head;

  always_comb begin
    empty      = (count == 2'd0);
    head_valid = !empty || push_valid;
    head_data  = '0;
    if (!empty) begin
      head_data = mem[rd_ptr];
    end else if (push_valid) begin
      head_data = push_data;
    end
    // An incoming word consumed straight through never occupies an entry.
    store     = push_valid && !(empty && head_ready);
    drop_head = head_valid && head_ready && !empty;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      if (reset) begin
        mem[0] <= '0;
        mem[1] <= '0;
      end
    end else begin
      if (store) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (drop_head) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, store} - {1'b0, drop_head};
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC fetch controller feeding the decode stage through a 2-entry buffer.
// Define MSEQ_LOOP_EN to build the loop counter (loop_count extra passes).
module micro_sequencer
  import mseq_pkg::*;
#(
  parameter int UADDR_W = UADDR_W_DEF,
  parameter int UWORD_W = UWORD_W_DEF,
  parameter int DADDR_W = DADDR_W_DEF,
  parameter int LOOP_W  = LOOP_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [UADDR_W-1:0] start_addr,
  input  logic [UADDR_W-1:0] end_addr,
  input  logic [LOOP_W-1:0]  loop_count,
  input  logic [DADDR_W-1:0] data_address_in,
  input  logic               halt,
  input  logic               branch_req,
  input  logic [UADDR_W-1:0] branch_target,
  output logic [UADDR_W-1:0] rom_addr,
  output logic               rom_en,
  input  logic [UWORD_W-1:0] rom_data,
  output logic [UWORD_W-1:0] micro_instr_out,
  output logic [UADDR_W-1:0] uaddr_out,
  output logic [DADDR_W-1:0] data_address_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               done
);

  localparam int BUF_W = UWORD_W + UADDR_W;

  mseq_state_t        state;
  logic [UADDR_W-1:0] upc;
  logic [UADDR_W-1:0] end_reg;
  logic               ret_valid;
  logic [UADDR_W-1:0] ret_addr;
  logic [1:0]         fifo_count;
  logic [BUF_W-1:0]   head_data;
  logic               pop;
  logic               flush;
  logic [2:0]         occupancy;
  logic               fetch_ok;
  logic               drained;

`ifdef MSEQ_LOOP_EN
  logic [UADDR_W-1:0] start_reg;
  logic [LOOP_W-1:0]  loop_rem;
`else
  logic unused_loop;
  assign unused_loop = ^loop_count;
`endif

  mseq_fifo2 #(.W(BUF_W)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_valid (ret_valid),
    .push_data  ({ret_addr, rom_data}),
    .head_valid (instr_valid),
    .head_data  (head_data),
    .head_ready (instr_ready),
    .count      (fifo_count)
  );

  assign {uaddr_out, micro_instr_out} = head_data;
  assign busy = (state != IDLE);

  // Words outstanding after this edge: buffered + returning + requested,
  // less the one leaving this cycle. Capped at 2 so the buffer never overflows.
  always_comb begin
    pop       = instr_valid && instr_ready;
    flush     = (state != IDLE) && (halt || branch_req);
    occupancy = {1'b0, fifo_count} + {2'b0, ret_valid} + {2'b0, rom_en} - {2'b0, pop};
    fetch_ok  = (occupancy < 3'd2);
    drained   = !rom_en && (occupancy == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      upc              <= '0;
      end_reg          <= '0;
      data_address_out <= '0;
      rom_en           <= 1'b0;
      rom_addr         <= '0;
      ret_valid        <= 1'b0;
      ret_addr         <= '0;
      done             <= 1'b0;
`ifdef MSEQ_LOOP_EN
      start_reg        <= '0;
      loop_rem         <= '0;
`endif
    end else begin
      done      <= 1'b0;
      rom_en    <= 1'b0;
      ret_valid <= rom_en;
      ret_addr  <= rom_addr;
      unique case (state)
        IDLE: begin
          if (start) begin
            upc              <= start_addr;
            end_reg          <= end_addr;
            data_address_out <= data_address_in;
`ifdef MSEQ_LOOP_EN
            start_reg        <= start_addr;
            loop_rem         <= loop_count;
`endif
            state            <= RUN;
          end
        end
        RUN, DRAIN: begin
          if (halt) begin
            state     <= IDLE;
            done      <= 1'b1;
            ret_valid <= 1'b0;
          end else if (branch_req) begin
            upc       <= branch_target;
            state     <= RUN;
            ret_valid <= 1'b0;
          end else if (state == RUN) begin
            if (fetch_ok) begin
              rom_en   <= 1'b1;
              rom_addr <= upc;
              upc      <= upc + UADDR_W'(1);
              if (upc == end_reg) begin
`ifdef MSEQ_LOOP_EN
                if (loop_rem != '0) begin
                  upc      <= start_reg;
                  loop_rem <= loop_rem - LOOP_W'(1);
                end else begin
                  state <= DRAIN;
                end
`else
                state <= DRAIN;
`endif
              end
            end
          end else if (drained) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: expected words come from a program-level
// address walk over a random ROM image; a negedge monitor pops and compares.
module tb_micro_sequencer;

  localparam int AW = 8;
  localparam int WW = 33;
  localparam int DW = 11;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [LW-1:0] loop_count = '0;
  logic [DW-1:0] data_address_in = '0;
  logic          halt = 1'b0;
  logic          branch_req = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] rom_addr;
  logic          rom_en;
  logic [WW-1:0] rom_data = '0;
  logic [WW-1:0] micro_instr_out;
  logic [AW-1:0] uaddr_out;
  logic [DW-1:0] data_address_out;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  micro_sequencer #(.UADDR_W(AW), .UWORD_W(WW), .DADDR_W(DW), .LOOP_W(LW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .start_addr       (start_addr),
    .end_addr         (end_addr),
    .loop_count       (loop_count),
    .data_address_in  (data_address_in),
    .halt             (halt),
    .branch_req       (branch_req),
    .branch_target    (branch_target),
    .rom_addr         (rom_addr),
    .rom_en           (rom_en),
    .rom_data         (rom_data),
    .micro_instr_out  (micro_instr_out),
    .uaddr_out        (uaddr_out),
    .data_address_out (data_address_out),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .busy             (busy),
    .done             (done)
  );

  logic [WW-1:0] rom_mem [256];
  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [WW-1:0] w;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = -1;
  int   xfer_cyc[$];
  int   ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Program model: one pass walks s, s+1, ... (mod 256) up to and including e.
  function automatic void push_prog(input logic [AW-1:0] s, input logic [AW-1:0] e,
                                    input int passes, input logic [DW-1:0] d);
    for (int p = 0; p < passes; p++) begin
      logic [AW-1:0] a;
      a = s;
      for (int k = 0; k < 256; k++) begin
        exp_q.push_back('{a: a, w: rom_mem[a], d: d});
        if (a == e) break;
        a = a + 8'd1;
      end
    end
  endfunction

  function automatic int passes_for(input logic [LW-1:0] lc);
`ifdef MSEQ_LOOP_EN
    return int'(lc) + 1;
`else
    return (lc == lc) ? 1 : 1;
`endif
  endfunction

  // Ready driver: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       instr_ready = 1'b1;
        1:       instr_ready = ($urandom_range(0, 9) < 7);
        default: instr_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  logic          prev_stall = 1'b0;
  logic          prev_flush = 1'b0;
  logic          prev_done = 1'b0;
  logic [51:0]   prev_out = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall && !prev_flush) begin
        check("stall_valid_held", 64'(instr_valid), 64'(1));
        check("stall_data_held", 64'({uaddr_out, micro_instr_out, data_address_out}), 64'(prev_out));
      end
      if (instr_valid && instr_ready) begin
        xfer_cyc.push_back(cyc);
        check("word_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          check("word", 64'({uaddr_out, micro_instr_out, data_address_out}), 64'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (done) begin
        check("done_one_cycle", 64'(prev_done), 64'(0));
        done_cnt++;
        last_done_cyc = cyc;
      end
      prev_stall = instr_valid && !instr_ready;
      prev_flush = halt || branch_req;
      prev_done  = done;
      prev_out   = {uaddr_out, micro_instr_out, data_address_out};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int done_base;

  task automatic start_prog(input logic [AW-1:0] s, input logic [AW-1:0] e,
                            input logic [LW-1:0] lc, input logic [DW-1:0] d, output int t0);
    start = 1'b1;
    start_addr = s;
    end_addr = e;
    loop_count = lc;
    data_address_in = d;
    t0 = cyc;
    done_base = done_cnt;
    push_prog(s, e, passes_for(lc), d);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (done_cnt == done_base && k < budget) begin
      tick();
      k++;
    end
    check({name, "_done"}, 64'(done_cnt - done_base), 64'(1));
    check({name, "_all_words"}, 64'(exp_q.size()), 64'(0));
    check({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic do_branch(input logic [AW-1:0] tg, input logic [AW-1:0] e, input logic [DW-1:0] d);
    branch_req = 1'b1;
    branch_target = tg;
    tick();
    branch_req = 1'b0;
    exp_q.delete();
    push_prog(tg, e, 1, d);
  endtask

  task automatic do_halt(input string name);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    exp_q.delete();
    wait_done(name, 4);
    check({name, "_valid_low"}, 64'(instr_valid), 64'(0));
  endtask

  task automatic basic_run(input string name);
    int t0;
    ready_mode = 0;
    xfer_cyc.delete();
    start_prog(8'h10, 8'h13, 8'd0, 11'h123, t0);
    wait_done(name, 50);
    check({name, "_xfers"}, 64'(xfer_cyc.size()), 64'(4));
    for (int i = 0; i < 4 && i < xfer_cyc.size(); i++)
      check({name, "_xfer_cycle"}, 64'(xfer_cyc[i]), 64'(t0 + 3 + i));
    check({name, "_done_cycle"}, 64'(last_done_cyc), 64'(t0 + 7));
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 256; i++) rom_mem[i] = {$urandom_range(0, 1), $urandom()};

    reset = 1'b1;
    repeat (3) tick();
    check("rst_rom_en", 64'(rom_en), 64'(0));
    check("rst_rom_addr", 64'(rom_addr), 64'(0));
    check("rst_valid", 64'(instr_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_outputs", 64'({micro_instr_out, uaddr_out, data_address_out}), 64'(0));
    reset = 1'b0;
    tick();

    // Back-to-back delivery and completion timing.
    basic_run("t1");

    // Mid-run stall.
    start_prog(8'h20, 8'h27, 8'd0, 11'h2AA, t0);
    repeat (3) tick();
    ready_mode = 2;
    repeat (3) tick();
    ready_mode = 0;
    wait_done("t2", 100);

    // Address wrap through zero.
    xfer_cyc.delete();
    start_prog(8'hFE, 8'h01, 8'd0, 11'h055, t0);
    wait_done("t3", 50);
    check("t3_xfers", 64'(xfer_cyc.size()), 64'(4));

    // Branch with one word buffered and the next returning.
    ready_mode = 2;
    start_prog(8'h05, 8'h42, 8'd0, 11'h400, t0);
    repeat (3) tick();
    check("t4_buffered", 64'({instr_valid, uaddr_out}), 64'({1'b1, 8'h05}));
    do_branch(8'h40, 8'h42, 11'h400);
    ready_mode = 0;
    xfer_cyc.delete();
    wait_done("t4", 50);
    check("t4_xfers", 64'(xfer_cyc.size()), 64'(3));

    // Halt, then reset, mid-program.
    start_prog(8'h50, 8'h5F, 8'd0, 11'h7FF, t0);
    repeat (3) tick();
    do_halt("t5_halt");
    start_prog(8'h60, 8'h6F, 8'd0, 11'h001, t0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("t5_rst_valid", 64'(instr_valid), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_done", 64'(done), 64'(0));
    repeat (2) begin
      tick();
      check("t5_post_rst_valid", 64'(instr_valid), 64'(0));
    end
    basic_run("t5_restart");

    // Loop passes.
    xfer_cyc.delete();
    start_prog(8'h30, 8'h31, 8'd2, 11'h030, t0);
    wait_done("t6", 100);
    check("t6_xfers", 64'(xfer_cyc.size()), 64'(2 * passes_for(8'd2)));

    // Randomised programs with back-pressure, branches and halts.
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] s, e;
      logic [LW-1:0] lc;
      logic [DW-1:0] d;
      int act;
      s   = AW'($urandom());
      e   = s + AW'($urandom_range(0, 7));
      lc  = LW'($urandom_range(0, 3));
      d   = DW'($urandom());
      act = $urandom_range(0, 5);
      if (act == 0) lc = '0;
      start_prog(s, e, lc, d, t0);
      repeat ($urandom_range(0, 8)) tick();
      if (busy && act == 0) do_branch(e - AW'($urandom_range(0, 5)), e, d);
      if (busy && act == 1) do_halt("rnd_halt");
      else wait_done("rnd", 400);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
